// File: rtl/spawn_if.sv
// Handshake bundle between the game FSM (master) and spawn_controller (slave).
// Commands are single-cycle strobes; results are valid while done is high.
interface spawn_if;
  logic                   cmd_new_game;
  logic                   cmd_spawn;
  logic [0:3][0:3][3:0]   grid_in;
  logic [1:0]             rand_x;
  logic [1:0]             rand_y;
  logic [2:0]             rand_v;
  logic [0:3][0:3][3:0]   grid_out;
  logic                   busy;
  logic                   done;
  logic                   spawned;
  logic                   full;
  logic [1:0]             state_dbg;

  modport master (
    output cmd_new_game, cmd_spawn, grid_in, rand_x, rand_y, rand_v,
    input  grid_out, busy, done, spawned, full, state_dbg
  );

  modport slave (
    input  cmd_new_game, cmd_spawn, grid_in, rand_x, rand_y, rand_v,
    output grid_out, busy, done, spawned, full, state_dbg
  );
endinterface

// File: rtl/spawn_controller.sv
// Tile spawner for the 4x4 grid: random tries, then a row-major fallback scan.
// Optional macro SPAWN_FOUR_EN: rand_v==0 spawns TILE_VAL+1 instead of TILE_VAL.
module spawn_controller #(
  parameter int MAX_TRIES = 4,
  parameter int TILE_VAL  = 1
) (
  input logic     clk,
  input logic     rst,
  spawn_if.slave  sif
);
  typedef enum logic [1:0] {IDLE = 2'd0, TRY = 2'd1, SCAN = 2'd2, DONE = 2'd3} state_t;
  typedef logic [0:3][0:3][3:0] grid_t;

  localparam logic [3:0] TILE      = 4'(TILE_VAL);
  localparam logic [3:0] LAST_TRY  = 4'(MAX_TRIES - 1);

  state_t      state;
  grid_t       work;
  logic [3:0]  tries;
  logic [3:0]  idx;
  logic [1:0]  remaining;
  logic        placed;

  logic [1:0]  cur_x, cur_y;
  logic        cell_empty;
  logic [3:0]  tile;
  grid_t       work_placed;
  logic [1:0]  rem_dec;

  always_comb begin
    cur_x       = (state == SCAN) ? idx[3:2] : sif.rand_x;
    cur_y       = (state == SCAN) ? idx[1:0] : sif.rand_y;
    cell_empty  = (work[cur_x][cur_y] == 4'd0);
`ifdef SPAWN_FOUR_EN
    tile        = (sif.rand_v == 3'b000) ? TILE + 4'd1 : TILE;
`else
    tile        = TILE;
`endif
    work_placed = work;
    work_placed[cur_x][cur_y] = tile;
    rem_dec     = remaining - 2'd1;
  end

`ifndef SPAWN_FOUR_EN
  logic unused_rand_v;
  assign unused_rand_v = ^sif.rand_v;
`endif

  assign sif.state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      work         <= '0;
      tries        <= 4'd0;
      idx          <= 4'd0;
      remaining    <= 2'd0;
      placed       <= 1'b0;
      sif.grid_out <= '0;
      sif.busy     <= 1'b0;
      sif.done     <= 1'b0;
      sif.spawned  <= 1'b0;
      sif.full     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sif.cmd_new_game || sif.cmd_spawn) begin
            work      <= sif.cmd_new_game ? '0 : sif.grid_in;
            remaining <= sif.cmd_new_game ? 2'd2 : 2'd1;
            tries     <= 4'd0;
            idx       <= 4'd0;
            placed    <= 1'b0;
            sif.full  <= 1'b0;
            sif.busy  <= 1'b1;
            state     <= TRY;
          end
        end
        TRY: begin
          if (cell_empty) begin
            work      <= work_placed;
            placed    <= 1'b1;
            tries     <= 4'd0;
            remaining <= rem_dec;
            if (rem_dec == 2'd0) begin
              // Results are registered on the way into DONE so they are visible with done.
              sif.grid_out <= work_placed;
              sif.spawned  <= 1'b1;
              sif.done     <= 1'b1;
              state        <= DONE;
            end
          end else if (tries == LAST_TRY) begin
            idx   <= 4'd0;
            state <= SCAN;
          end else begin
            tries <= tries + 4'd1;
          end
        end
        SCAN: begin
          if (cell_empty) begin
            work      <= work_placed;
            placed    <= 1'b1;
            remaining <= rem_dec;
            if (rem_dec == 2'd0) begin
              sif.grid_out <= work_placed;
              sif.spawned  <= 1'b1;
              sif.done     <= 1'b1;
              state        <= DONE;
            end else begin
              tries <= 4'd0;
              state <= TRY;
            end
          end else if (idx == 4'd15) begin
            sif.grid_out <= work;
            sif.spawned  <= placed;
            sif.full     <= 1'b1;
            sif.done     <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          sif.done <= 1'b0;
          sif.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spawn_controller.md
Name: spawn_controller

Overview:
- Sequences tile spawning for the 4x4 game grid. Each grid cell is a 4-bit exponent, and 0 means the cell is empty.
- On a new-game command it clears the grid and places two tiles. On a spawn command, issued after each move, it places one tile into a snapshot of the current grid.
- It tries random coordinates for a bounded number of cycles. If none of them is empty, it falls back to a deterministic scan.
- It reports completion and a full-grid condition to the game FSM.

Parameters:
- MAX_TRIES, 4: number of random placement attempts before the fallback scan; legal range 1..15.
- TILE_VAL, 1: exponent written into a spawned cell (1 = tile "2").

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- cmd_new_game  input  1  one-cycle request: clear grid, spawn two tiles.
- cmd_spawn  input  1  one-cycle request: spawn one tile into grid_in.
- grid_in  input  4 x [0:3][0:3]  current grid; sampled only when cmd_spawn is accepted.
- rand_x  input  2  random row from the LFSR block; sampled every TRY cycle.
- rand_y  input  2  random column from the LFSR block; sampled every TRY cycle.
- rand_v  input  3  random value bits; used only with SPAWN_FOUR_EN.
- grid_out  output  4 x [0:3][0:3]  registered result grid.
- busy  output  1  high from the cycle after acceptance until the done cycle inclusive.
- done  output  1  one-cycle completion pulse.
- spawned  output  1  at least one tile placed in the last operation; valid when done is high, held until the next done.
- full  output  1  no empty cell found for a required placement; valid when done is high, held until the next done.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - grid_out all zero; busy, done, spawned and full all 0.
  - Internal work grid, try counter, scan index and remaining count all 0.
- IDLE:
  - Commands are accepted only in IDLE. Commands arriving while busy are ignored and not queued.
  - cmd_new_game has priority over cmd_spawn when both are high.
  - On cmd_new_game: work grid <= all 0, remaining <= 2, tries <= 0; go to TRY.
  - On cmd_spawn: work grid <= grid_in, remaining <= 1, tries <= 0; go to TRY.
- TRY, one attempt per cycle:
  - If work[rand_x][rand_y]==0: write the tile value, decrement remaining, tries <= 0. If remaining reaches 0, go to DONE; otherwise stay in TRY.
  - If the cell is occupied and tries==MAX_TRIES-1: go to SCAN with idx <= 0.
  - If the cell is occupied otherwise: tries <= tries+1.
- SCAN, one cell per cycle:
  - Cell order is row-major: x=idx[3:2], y=idx[1:0], idx runs 0..15.
  - At the first empty cell: write the tile value and decrement remaining. If remaining reaches 0, go to DONE; otherwise return to TRY with tries <= 0.
  - If idx==15 and that cell is occupied: full <= 1, go to DONE.
  - Otherwise idx <= idx+1.
- DONE, one cycle:
  - grid_out <= work grid, done=1.
  - spawned=1 if any tile was placed in this operation.
  - full is cleared at acceptance of each new operation and set only as described under SCAN.
  - Next state is IDLE.
- Latency:
  - Spawn with an empty first random cell: accept at cycle 0, TRY at cycle 1, done at cycle 2.
  - Worst case for one tile: 2 + MAX_TRIES + 16 cycles.
- grid_out changes only in DONE. Between operations it holds its value, and grid_in changes have no effect.
- Both tiles of a new game always land in distinct cells, because the second attempt sees the first placement in the work grid.
- Reset mid-operation aborts immediately; all outputs return to reset values.

Optional Feature:
- Macro: SPAWN_FOUR_EN.
- Defined: at each placement, if rand_v==3'b000 the written value is TILE_VAL+1 (tile "4", probability 1/8); otherwise it is TILE_VAL.
- Undefined: rand_v is ignored, and every spawn writes TILE_VAL.

Test Plan:
- Reset, then cmd_new_game with rand sequence (1,2),(1,2),(3,0) -> done in cycle 4; grid_out [1][2]=1 and [3][0]=1, all other cells 0; spawned=1, full=0.
- cmd_spawn with grid_in all 0 and rand=(0,0) -> done at cycle 2; only grid_out[0][0]=1; busy high in cycles 1-2.
- cmd_spawn with grid_in all 3 except [2][1]=0, rand held at (0,0), MAX_TRIES=4 -> 4 TRY cycles, scan reaches idx 9, done at cycle 15; grid_out[2][1]=1.
- cmd_spawn with grid_in all 5 -> full=1, spawned=0, grid_out equals grid_in, done after 4 TRY + 16 SCAN cycles.
- cmd_spawn pulsed again while busy, plus cmd_new_game and cmd_spawn asserted together in IDLE -> the second request is ignored; new game wins, with remaining=2 and a cleared grid.
- With SPAWN_FOUR_EN, cmd_spawn with grid_in all 0, rand=(2,2), rand_v=0 -> grid_out[2][2]=2. Separately, assert rst low during TRY -> all outputs read 0 asynchronously.
